fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Multi-cycle instruction-fetch controller that owns the PC and sequences fetches from a handshaked instruction memory.
- Presents one instruction at a time to decode, with a valid/ready handshake.
- Accepts branch/jump redirects from the existing PC next-address logic (taken target or register target).
- Replaces the free-running PC register when memory latency is variable.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 16, REQ cycles without ack before fetch error (only with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  [0:31]  fetch address (bit 0 = MSB)
imem_ack  input  1  memory completes current request; imem_rdata valid this cycle
imem_rdata  input  [0:31]  fetched instruction word
inst_valid  output  1  inst_out/inst_pc hold a valid instruction
inst_ready  input  1  decode accepts instruction
inst_out  output  [0:31]  instruction word to decode
inst_pc  output  [0:31]  address of inst_out
save_addr  output  [0:31]  inst_pc + 4 (link address)
redirect  input  1  taken branch/jump/register-jump this cycle
redirect_addr  input  [0:31]  new PC target
fetch_err  output  1  fetch timeout flag (0 without FETCH_TIMEOUT_EN)

Behaviour:
- Reset: state IDLE; pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; inst_valid=0; inst_out=0; inst_pc=0; save_addr=32'h4; fetch_err=0; squash=0.
- States: IDLE, REQ, HOLD, STOP. All outputs are registered.
- IDLE: moves to REQ unconditionally on the next edge. Any imem_ack seen in IDLE is ignored.
- REQ: imem_req=1 and imem_addr=pc. The address stays stable until imem_ack.
- REQ, on ack with no squash and no redirect:
  - inst_out <= imem_rdata; inst_pc <= pc; pc <= pc+4.
  - Move to HOLD with inst_valid=1.
  - Minimum latency from REQ entry to inst_valid is 1 cycle if ack arrives in the first REQ cycle.
- REQ, redirect without ack: pc <= redirect_addr and squash <= 1. The outstanding request must still complete.
- REQ, ack with squash=1 or redirect=1:
  - Data is discarded and squash is cleared.
  - pc <= redirect_addr if redirect=1, else pc is unchanged (already the target).
  - Stay in REQ with the new address.
- HOLD:
  - inst_valid=1 until inst_ready. A transfer occurs when inst_valid and inst_ready are both 1.
  - On transfer: inst_valid <= 0, then REQ.
  - Redirect without transfer: held instruction dropped (inst_valid <= 0), pc <= redirect_addr, then REQ.
  - Redirect with transfer: the transfer completes and pc <= redirect_addr.
- Redirect in IDLE: pc <= redirect_addr.
- If several redirects arrive before the squashed ack, the latest redirect_addr wins.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0). redirect_addr bits [30:31] are forced to 0 on load.
- Throughput: at best 1 instruction per 2 cycles.
- Reset asserted mid-operation returns the block to the reset state immediately. A stale ack is ignored.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while in REQ and clears on ack or on leaving REQ.
  - When the count reaches TIMEOUT_CYCLES: fetch_err <= 1 (sticky until reset), imem_req <= 0, state moves to STOP.
  - STOP ignores all inputs until reset.
- Undefined: no counter; fetch_err tied 0; STOP is unreachable; REQ waits indefinitely.

Decomposition:
- Shared package fetch_pkg:
  - State enum (IDLE, REQ, HOLD, STOP).
  - PC_STEP = 32'h4 and WORD_ALIGN_MASK = 32'hFFFF_FFFC.
  - Width constant ADDR_W = 32.
- One natural sub-module: fetch_timeout_ctr, the timeout counter instantiated only under FETCH_TIMEOUT_EN.
- The PC and the output holding registers use the existing register32.

Test Plan:
- Reset release, imem_ack=1 in the first REQ cycle, inst_ready=1 -> imem_addr 0x0, 0x4, 0x8; inst_pc 0x0, 0x4, 0x8; save_addr 0x4, 0x8, 0xC.
- Ack delayed 5 cycles at pc=0x10 -> imem_req and imem_addr=0x10 held for 5 cycles; inst_out = rdata; inst_valid 1 cycle later.
- Redirect to 0x100 while REQ at 0x20 is unacked; ack 3 cycles later -> that data dropped, inst_valid stays 0, next imem_addr=0x100.
- HOLD with inst_ready=0 for 4 cycles, then redirect to 0x203 -> held instruction dropped; next imem_addr=0x200.
- pc=0xFFFF_FFFC fetched and transferred -> next imem_addr=0x0000_0000.
- With FETCH_TIMEOUT_EN, no ack for 16 cycles -> fetch_err=1, imem_req=0; stays until reset, then all outputs at reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned ADDR_W = 32;

    // Sequential fetch stride and the mask that word-aligns redirect targets.
    localparam logic [0:ADDR_W-1] PC_STEP         = 32'h0000_0004;
    localparam logic [0:ADDR_W-1] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // IDLE : one cycle after reset before the first request
    // REQ  : request outstanding, waiting for imem_ack
    // HOLD : instruction presented to decode, waiting for inst_ready
    // STOP : fetch timed out; only reset leaves this state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        STOP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts consecutive request cycles without an acknowledge and flags the
// cycle in which the count reaches TIMEOUT_CYCLES.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    input  logic i_ack,
    output logic o_expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    // The current cycle is the TIMEOUT_CYCLES-th unacknowledged request cycle.
    assign w_last    = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
    assign o_expired = i_run && !i_ack && w_last;

    // Count unacknowledged request cycles; clear on ack or outside REQ.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (!i_run || i_ack || w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/register32.sv
// 32-bit enabled register with asynchronous active-high reset to a
// parameterised value. Bit 0 is the MSB.
module register32
    import fetch_pkg::*;
#(
    parameter logic [0:ADDR_W-1] RESET_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [0:ADDR_W-1] i_d,
    output logic [0:ADDR_W-1] o_q
);

    logic [0:ADDR_W-1] r_q;

    // Load on enable, otherwise hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction-fetch controller: owns the PC, issues handshaked
// requests to instruction memory and presents one instruction at a time to
// decode. Branch/jump redirects retarget the PC; a redirect that lands while
// a request is outstanding squashes the data of that request.
// Optional feature: define FETCH_TIMEOUT_EN to enable the request timeout
// (fetch_err, STOP state). Without it fetch_err is tied low.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [0:ADDR_W-1] RESET_PC       = 32'h0000_0000,
    parameter int unsigned       TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [0:ADDR_W-1] imem_addr,
    input  logic              imem_ack,
    input  logic [0:ADDR_W-1] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [0:ADDR_W-1] inst_out,
    output logic [0:ADDR_W-1] inst_pc,
    output logic [0:ADDR_W-1] save_addr,
    input  logic              redirect,
    input  logic [0:ADDR_W-1] redirect_addr,
    output logic              fetch_err
);

    fetch_state_e r_state, w_state_nxt;
    logic         r_squash, w_squash_nxt;
    logic         r_valid, w_valid_nxt;
    logic         r_req, w_req_nxt;
    logic         r_err;

    logic [0:ADDR_W-1] w_pc, w_pc_d, w_pc_inc, w_tgt;
    logic [0:ADDR_W-1] w_addr_d;
    logic              w_pc_en, w_addr_en, w_inst_en;
    logic              w_timeout;

    assign w_tgt    = redirect_addr & WORD_ALIGN_MASK;
    assign w_pc_inc = w_pc + PC_STEP;

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_run     (r_state == REQ),
        .i_ack     (imem_ack),
        .o_expired (w_timeout)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
`endif

    // Next-state, handshake and register-load decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_squash_nxt = r_squash;
        w_valid_nxt  = r_valid;
        w_req_nxt    = r_req;
        w_pc_en      = 1'b0;
        w_pc_d       = w_pc;
        w_addr_en    = 1'b0;
        w_addr_d     = w_pc;
        w_inst_en    = 1'b0;

        case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
                w_req_nxt   = 1'b1;
                w_addr_en   = 1'b1;
                if (redirect) begin
                    w_pc_en  = 1'b1;
                    w_pc_d   = w_tgt;
                    w_addr_d = w_tgt;
                end
            end

            REQ: begin
                if (w_timeout) begin
                    w_state_nxt = STOP;
                    w_req_nxt   = 1'b0;
                end else if (imem_ack) begin
                    if (r_squash || redirect) begin
                        // Returned word belongs to a stale address: drop it
                        // and reissue at the (possibly just updated) target.
                        w_squash_nxt = 1'b0;
                        w_addr_en    = 1'b1;
                        if (redirect) begin
                            w_pc_en  = 1'b1;
                            w_pc_d   = w_tgt;
                            w_addr_d = w_tgt;
                        end
                    end else begin
                        w_inst_en   = 1'b1;
                        w_pc_en     = 1'b1;
                        w_pc_d      = w_pc_inc;
                        w_valid_nxt = 1'b1;
                        w_req_nxt   = 1'b0;
                        w_state_nxt = HOLD;
                    end
                end else if (redirect) begin
                    // Address to memory stays put until the ack arrives.
                    w_pc_en      = 1'b1;
                    w_pc_d       = w_tgt;
                    w_squash_nxt = 1'b1;
                end
            end

            HOLD: begin
                if (inst_ready || redirect) begin
                    w_valid_nxt = 1'b0;
                    w_req_nxt   = 1'b1;
                    w_addr_en   = 1'b1;
                    w_state_nxt = REQ;
                    if (redirect) begin
                        w_pc_en  = 1'b1;
                        w_pc_d   = w_tgt;
                        w_addr_d = w_tgt;
                    end
                end
            end

            STOP: begin
                w_state_nxt = STOP;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and single-bit control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_squash <= 1'b0;
            r_valid  <= 1'b0;
            r_req    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_squash <= w_squash_nxt;
            r_valid  <= w_valid_nxt;
            r_req    <= w_req_nxt;
            r_err    <= r_err | w_timeout;
        end
    end

    register32 #(.RESET_VAL(RESET_PC)) u_pc (
        .i_clk (clk), .i_rst (reset), .i_en (w_pc_en), .i_d (w_pc_d), .o_q (w_pc)
    );

    register32 #(.RESET_VAL(RESET_PC)) u_addr (
        .i_clk (clk), .i_rst (reset), .i_en (w_addr_en), .i_d (w_addr_d), .o_q (imem_addr)
    );

    register32 #(.RESET_VAL('0)) u_inst (
        .i_clk (clk), .i_rst (reset), .i_en (w_inst_en), .i_d (imem_rdata), .o_q (inst_out)
    );

    register32 #(.RESET_VAL('0)) u_inst_pc (
        .i_clk (clk), .i_rst (reset), .i_en (w_inst_en), .i_d (w_pc), .o_q (inst_pc)
    );

    register32 #(.RESET_VAL(PC_STEP)) u_save (
        .i_clk (clk), .i_rst (reset), .i_en (w_inst_en), .i_d (w_pc_inc), .o_q (save_addr)
    );

    assign imem_req   = r_req;
    assign inst_valid = r_valid;
    assign fetch_err  = r_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
// Timeout checks are compiled when FETCH_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [0:31] imem_addr;
    logic        imem_ack = 1'b0;
    logic [0:31] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [0:31] inst_out;
    logic [0:31] inst_pc;
    logic [0:31] save_addr;
    logic        redirect = 1'b0;
    logic [0:31] redirect_addr = '0;
    logic        fetch_err;

    fetch_sequencer #(
        .RESET_PC       (32'h0000_0000),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .save_addr     (save_addr),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: what the fetch unit is doing, described as flags.
    bit          m_started;   // first cycle after reset has passed
    bit          m_busy;      // a memory request is outstanding
    bit          m_drop;      // outstanding request's data is to be thrown away
    bit          m_hold;      // an instruction is offered to decode
    bit          m_stop;
    bit          m_err;
    logic [31:0] m_pc, m_addr, m_inst, m_ipc, m_save;
    int unsigned m_wait;

    typedef struct {
        bit          ack, rdy, rd;
        logic [31:0] ra, rdt;
        bit          e_req, e_valid;
        logic [31:0] e_addr, e_out, e_pc, e_save;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_busy = 0; m_drop = 0; m_hold = 0; m_stop = 0; m_err = 0;
        m_pc = 32'h0; m_addr = 32'h0; m_inst = 32'h0; m_ipc = 32'h0; m_save = 32'h4;
        m_wait = 0;
    endtask

    task automatic model_step(input bit a, input bit r, input bit rd,
                              input logic [31:0] ra, input logic [31:0] rdt);
        logic [31:0] tgt;
        tgt = {ra[31:2], 2'b00};
        if (m_stop) return;
        if (!m_started) begin
            m_started = 1;
            if (rd) m_pc = tgt;
            m_busy = 1; m_addr = m_pc; m_wait = 0;
        end else if (m_busy) begin
            if (a) begin
                m_wait = 0;
                if (m_drop || rd) begin
                    m_drop = 0;
                    if (rd) m_pc = tgt;
                    m_addr = m_pc;
                end else begin
                    m_inst = rdt; m_ipc = m_pc; m_pc = m_pc + 32'd4; m_save = m_pc;
                    m_busy = 0; m_hold = 1;
                end
            end else begin
`ifdef FETCH_TIMEOUT_EN
                m_wait++;
                if (m_wait == TO) begin
                    m_stop = 1; m_err = 1; m_busy = 0;
                    return;
                end
`endif
                if (rd) begin m_pc = tgt; m_drop = 1; end
            end
        end else if (m_hold) begin
            if (r || rd) begin
                m_hold = 0;
                if (rd) m_pc = tgt;
                m_busy = 1; m_addr = m_pc;
            end
        end
    endtask

    task automatic compare_all();
        chk("imem_req",   imem_req,   m_busy);
        chk("imem_addr",  imem_addr,  m_addr);
        chk("inst_valid", inst_valid, m_hold);
        chk("inst_out",   inst_out,   m_inst);
        chk("inst_pc",    inst_pc,    m_ipc);
        chk("save_addr",  save_addr,  m_save);
        chk("fetch_err",  fetch_err,  m_err);
    endtask

    // One clock: drive inputs, advance model at the edge, compare after it.
    task automatic cyc(input bit a, input bit r, input bit rd,
                       input logic [31:0] ra, input logic [31:0] rdt);
        imem_ack = a; inst_ready = r; redirect = rd; redirect_addr = ra; imem_rdata = rdt;
        @(posedge clk);
        model_step(a, r, rd, ra, rdt);
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        imem_ack = 0; inst_ready = 0; redirect = 0;
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        compare_all();
    endtask

    initial begin
        tbl[0] = '{ack:1'b1, rdy:1'b1, rd:1'b0, ra:32'h0, rdt:32'hAAAA_0000, e_req:1'b1, e_valid:1'b0,
                   e_addr:32'h0, e_out:32'h0,         e_pc:32'h0, e_save:32'h4};
        tbl[1] = '{ack:1'b1, rdy:1'b1, rd:1'b0, ra:32'h0, rdt:32'h1111_1111, e_req:1'b0, e_valid:1'b1,
                   e_addr:32'h0, e_out:32'h1111_1111, e_pc:32'h0, e_save:32'h4};
        tbl[2] = '{ack:1'b0, rdy:1'b1, rd:1'b0, ra:32'h0, rdt:32'h0,         e_req:1'b1, e_valid:1'b0,
                   e_addr:32'h4, e_out:32'h1111_1111, e_pc:32'h0, e_save:32'h4};
        tbl[3] = '{ack:1'b1, rdy:1'b1, rd:1'b0, ra:32'h0, rdt:32'h2222_2222, e_req:1'b0, e_valid:1'b1,
                   e_addr:32'h4, e_out:32'h2222_2222, e_pc:32'h4, e_save:32'h8};
        tbl[4] = '{ack:1'b0, rdy:1'b1, rd:1'b0, ra:32'h0, rdt:32'h0,         e_req:1'b1, e_valid:1'b0,
                   e_addr:32'h8, e_out:32'h2222_2222, e_pc:32'h4, e_save:32'h8};
        tbl[5] = '{ack:1'b1, rdy:1'b1, rd:1'b0, ra:32'h0, rdt:32'h3333_3333, e_req:1'b0, e_valid:1'b1,
                   e_addr:32'h8, e_out:32'h3333_3333, e_pc:32'h8, e_save:32'hC};
        tbl[6] = '{ack:1'b0, rdy:1'b1, rd:1'b0, ra:32'h0, rdt:32'h0,         e_req:1'b1, e_valid:1'b0,
                   e_addr:32'hC, e_out:32'h3333_3333, e_pc:32'h8, e_save:32'hC};

        // Reset values
        apply_reset();
        chk("rst.req",   imem_req,   32'h0);
        chk("rst.addr",  imem_addr,  32'h0);
        chk("rst.valid", inst_valid, 32'h0);
        chk("rst.out",   inst_out,   32'h0);
        chk("rst.pc",    inst_pc,    32'h0);
        chk("rst.save",  save_addr,  32'h4);
        chk("rst.err",   fetch_err,  32'h0);

        // Back-to-back sequential fetch, ack in first REQ cycle
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].ack, tbl[i].rdy, tbl[i].rd, tbl[i].ra, tbl[i].rdt);
            chk($sformatf("vec%0d.req", i),   imem_req,   tbl[i].e_req);
            chk($sformatf("vec%0d.valid", i), inst_valid, tbl[i].e_valid);
            chk($sformatf("vec%0d.addr", i),  imem_addr,  tbl[i].e_addr);
            chk($sformatf("vec%0d.out", i),   inst_out,   tbl[i].e_out);
            chk($sformatf("vec%0d.pc", i),    inst_pc,    tbl[i].e_pc);
            chk($sformatf("vec%0d.save", i),  save_addr,  tbl[i].e_save);
        end

        // Ack delayed 5 cycles at 0x10
        apply_reset();
        cyc(0, 0, 1, 32'h10, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 32'h0, 32'h0);
            chk("dly.req",  imem_req,  32'h1);
            chk("dly.addr", imem_addr, 32'h10);
            chk("dly.valid", inst_valid, 32'h0);
        end
        cyc(1, 0, 0, 32'h0, 32'hDEAD_BEEF);
        chk("dly.valid1", inst_valid, 32'h1);
        chk("dly.out",   inst_out,   32'hDEAD_BEEF);
        chk("dly.pc",    inst_pc,    32'h10);
        chk("dly.save",  save_addr,  32'h14);
        cyc(0, 1, 0, 32'h0, 32'h0);
        chk("dly.next", imem_addr, 32'h14);

        // Redirect while REQ at 0x20 unacked; ack 3 cycles later is dropped
        apply_reset();
        cyc(0, 0, 1, 32'h20, 32'h0);
        cyc(0, 0, 1, 32'h100, 32'h0);
        chk("sq.addr_hold", imem_addr, 32'h20);
        cyc(0, 0, 0, 32'h0, 32'h0);
        cyc(0, 0, 0, 32'h0, 32'h0);
        cyc(1, 1, 0, 32'h0, 32'hBAD0_BAD0);
        chk("sq.valid", inst_valid, 32'h0);
        chk("sq.req",   imem_req,   32'h1);
        chk("sq.addr",  imem_addr,  32'h100);
        cyc(1, 0, 0, 32'h0, 32'h600D_0100);
        chk("sq.pc",  inst_pc,  32'h100);
        chk("sq.out", inst_out, 32'h600D_0100);

        // HOLD stalled 4 cycles, then redirect to unaligned 0x203
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 32'h0, 32'h0);
            chk("hold.valid", inst_valid, 32'h1);
        end
        cyc(0, 0, 1, 32'h203, 32'h0);
        chk("hold.drop", inst_valid, 32'h0);
        chk("hold.addr", imem_addr,  32'h200);

        // PC wrap at top of address space
        apply_reset();
        cyc(0, 0, 1, 32'hFFFF_FFFC, 32'h0);
        cyc(1, 0, 0, 32'h0, 32'h1234_5678);
        chk("wrap.pc",   inst_pc,   32'hFFFF_FFFC);
        chk("wrap.save", save_addr, 32'h0);
        cyc(0, 1, 0, 32'h0, 32'h0);
        chk("wrap.addr", imem_addr, 32'h0);

        // Asynchronous reset mid-request, stale ack held across release
        cyc(0, 0, 1, 32'h440, 32'h0);
        imem_ack = 1;
        reset = 1;
        #1;
        model_reset();
        compare_all();
        chk("arst.req", imem_req, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        cyc(1, 1, 0, 32'h0, 32'h5A5A_5A5A);
        chk("stale.valid", inst_valid, 32'h0);
        chk("stale.addr",  imem_addr,  32'h0);
        chk("stale.req",   imem_req,   32'h1);

`ifdef FETCH_TIMEOUT_EN
        // Timeout: 16 unacked REQ cycles -> sticky error, STOP
        apply_reset();
        cyc(0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < TO - 1; i++) cyc(0, 0, 0, 32'h0, 32'h0);
        chk("to.err_early", fetch_err, 32'h0);
        cyc(0, 0, 0, 32'h0, 32'h0);
        chk("to.err", fetch_err, 32'h1);
        chk("to.req", imem_req,  32'h0);
        for (int i = 0; i < 6; i++) cyc(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
        chk("to.sticky", fetch_err, 32'h1);
        chk("to.stop",   imem_req,  32'h0);
        apply_reset();
        chk("to.rst_err", fetch_err, 32'h0);
        chk("to.rst_save", save_addr, 32'h4);
`else
        // Without timeout, an unanswered request waits indefinitely
        apply_reset();
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 32'h0, 32'h0);
        chk("nto.req", imem_req,  32'h1);
        chk("nto.err", fetch_err, 32'h0);
`endif

        // Randomized traffic against the model
        apply_reset();
        begin
            int unsigned wait_n;
            bit a;
            wait_n = 0;
            for (int i = 0; i < 600; i++) begin
                a = m_busy && (($urandom_range(0, 9) < 4) || wait_n >= 8);
                if (m_busy && !a) wait_n++; else wait_n = 0;
                cyc(a, $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0, $urandom, $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
